// File: rtl/exec_unit_sequencer.sv
// exec_unit_sequencer
//   Issue/completion sequencer for NUM_UNITS multi-cycle execution units.
//   Only one operation is in flight at a time. The sequencer supports per-op
//   timeout, abort, illegal-select detection and last-op latency capture.
//   All outputs are registered.
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   start           - single-cycle issue request (sampled with unit_sel/op)
//   unit_sel, op    - target unit index and operation code
//   abort           - cancel the in-flight operation
//   unit_ready      - per-unit completion strobe
//   unit_valid      - one-hot request to the selected unit, held while busy
//   unit_op         - latched operation code
//   busy            - operation in flight
//   done            - one-cycle completion pulse
//   timeout_err     - one-cycle pulse, operation abandoned after timeout
//   illegal_sel     - one-cycle pulse, start with unit_sel >= NUM_UNITS
//   last_latency    - WAIT cycles of the last completed operation (saturating)
module exec_unit_sequencer #(
    parameter int unsigned NUM_UNITS      = 2,
    parameter int unsigned SEL_WIDTH      = 1,
    parameter int unsigned OP_WIDTH       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SEL_WIDTH-1:0] unit_sel,
    input  logic [OP_WIDTH-1:0]  op,
    input  logic                 abort,
    input  logic [NUM_UNITS-1:0] unit_ready,
    output logic [NUM_UNITS-1:0] unit_valid,
    output logic [OP_WIDTH-1:0]  unit_op,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 illegal_sel,
    output logic [CNT_WIDTH-1:0] last_latency
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state, state_d;
    logic [NUM_UNITS-1:0]   valid_d;
    logic [OP_WIDTH-1:0]    op_d;
    logic                   busy_d, done_d, timeout_d, illegal_d;
    logic [CNT_WIDTH-1:0]   latency_d;
    logic [CNT_WIDTH-1:0]   cnt, cnt_d;

    logic                   sel_ok;
    logic [NUM_UNITS-1:0]   sel_onehot;
    logic                   ready_hit;
    logic                   timeout_hit;

    assign sel_ok      = (32'(unit_sel) < NUM_UNITS);
    assign sel_onehot  = NUM_UNITS'(1) << unit_sel;
    // unit_valid is one-hot at the latched index in WAIT, so masking with it
    // selects the ready strobe of the active unit without a variable index.
    assign ready_hit   = |(unit_ready & unit_valid);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt) == TIMEOUT_CYCLES);

    always_comb begin
        state_d   = state;
        valid_d   = unit_valid;
        op_d      = unit_op;
        busy_d    = busy;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        illegal_d = 1'b0;
        latency_d = last_latency;
        cnt_d     = cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    if (sel_ok) begin
                        state_d = WAIT;
                        valid_d = sel_onehot;
                        op_d    = op;
                        busy_d  = 1'b1;
                        // Counter is cleared and pre-incremented so it
                        // reads 1 during the first WAIT cycle.
                        cnt_d   = CNT_WIDTH'(1);
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                // ready wins over abort, abort wins over timeout
                if (ready_hit) begin
                    state_d   = IDLE;
                    valid_d   = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    latency_d = cnt;
                end else if (abort) begin
                    state_d = IDLE;
                    valid_d = '0;
                    busy_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    valid_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            unit_valid   <= '0;
            unit_op      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            illegal_sel  <= 1'b0;
            last_latency <= '0;
            cnt          <= '0;
        end else begin
            state        <= state_d;
            unit_valid   <= valid_d;
            unit_op      <= op_d;
            busy         <= busy_d;
            done         <= done_d;
            timeout_err  <= timeout_d;
            illegal_sel  <= illegal_d;
            last_latency <= latency_d;
            cnt          <= cnt_d;
        end
    end

endmodule

// File: tb/tb_exec_unit_sequencer.sv
// tb_exec_unit_sequencer
//   Directed bench for exec_unit_sequencer. Three instances:
//     a: NUM_UNITS=2, TIMEOUT_CYCLES=8                 (main behaviour)
//     b: NUM_UNITS=3, SEL_WIDTH=2                       (illegal select)
//     c: NUM_UNITS=2, TIMEOUT_CYCLES=0, CNT_WIDTH=3     (saturation, no timeout)
//   "Cycle n" is the interval after rising edge n; inputs set in cycle n are
//   sampled at the edge ending it and registered outputs appear in cycle n+1.
module tb_exec_unit_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // instance a
    logic       s_a, ab_a;
    logic [0:0] sel_a;
    logic [2:0] op_a;
    logic [1:0] rdy_a, val_a;
    logic [2:0] uop_a;
    logic       busy_a, done_a, to_a, ill_a;
    logic [7:0] lat_a;

    // instance b
    logic       s_b, ab_b;
    logic [1:0] sel_b;
    logic [2:0] op_b;
    logic [2:0] rdy_b, val_b;
    logic [2:0] uop_b;
    logic       busy_b, done_b, to_b, ill_b;
    logic [7:0] lat_b;

    // instance c
    logic       s_c, ab_c;
    logic [0:0] sel_c;
    logic [2:0] op_c;
    logic [1:0] rdy_c, val_c;
    logic [2:0] uop_c;
    logic       busy_c, done_c, to_c, ill_c;
    logic [2:0] lat_c;

    exec_unit_sequencer #(
        .NUM_UNITS(2), .SEL_WIDTH(1), .OP_WIDTH(3), .TIMEOUT_CYCLES(8), .CNT_WIDTH(8)
    ) dut_a (
        .clk(clk), .reset(reset), .start(s_a), .unit_sel(sel_a), .op(op_a),
        .abort(ab_a), .unit_ready(rdy_a), .unit_valid(val_a), .unit_op(uop_a),
        .busy(busy_a), .done(done_a), .timeout_err(to_a), .illegal_sel(ill_a),
        .last_latency(lat_a)
    );

    exec_unit_sequencer #(
        .NUM_UNITS(3), .SEL_WIDTH(2), .OP_WIDTH(3), .TIMEOUT_CYCLES(64), .CNT_WIDTH(8)
    ) dut_b (
        .clk(clk), .reset(reset), .start(s_b), .unit_sel(sel_b), .op(op_b),
        .abort(ab_b), .unit_ready(rdy_b), .unit_valid(val_b), .unit_op(uop_b),
        .busy(busy_b), .done(done_b), .timeout_err(to_b), .illegal_sel(ill_b),
        .last_latency(lat_b)
    );

    exec_unit_sequencer #(
        .NUM_UNITS(2), .SEL_WIDTH(1), .OP_WIDTH(3), .TIMEOUT_CYCLES(0), .CNT_WIDTH(3)
    ) dut_c (
        .clk(clk), .reset(reset), .start(s_c), .unit_sel(sel_c), .op(op_c),
        .abort(ab_c), .unit_ready(rdy_c), .unit_valid(val_c), .unit_op(uop_c),
        .busy(busy_c), .done(done_c), .timeout_err(to_c), .illegal_sel(ill_c),
        .last_latency(lat_c)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        s_a = 0; ab_a = 0; sel_a = 0; op_a = 0; rdy_a = 0;
        s_b = 0; ab_b = 0; sel_b = 0; op_b = 0; rdy_b = 0;
        s_c = 0; ab_c = 0; sel_c = 0; op_c = 0; rdy_c = 0;
        tick(); tick();
        check("rst_valid", 32'(val_a), 0);
        check("rst_op",    32'(uop_a), 0);
        check("rst_busy",  32'(busy_a), 0);
        check("rst_done",  32'(done_a), 0);
        check("rst_to",    32'(to_a), 0);
        check("rst_ill",   32'(ill_a), 0);
        check("rst_lat",   32'(lat_a), 0);
        reset = 1'b0;
        tick();

        // T1: sel=1 op=3 at cycle 0, ready[1] at cycle 5 -> done@6, latency 5
        s_a = 1; sel_a = 1; op_a = 3;
        tick(); s_a = 0; op_a = 0;
        for (int c = 1; c <= 5; c++) begin
            check("t1_valid", 32'(val_a), 32'h2);
            check("t1_op",    32'(uop_a), 3);
            check("t1_busy",  32'(busy_a), 1);
            check("t1_done",  32'(done_a), 0);
            if (c == 5) rdy_a = 2'b10;
            tick();
        end
        rdy_a = 0;
        check("t1_done6",  32'(done_a), 1);
        check("t1_busy6",  32'(busy_a), 0);
        check("t1_valid6", 32'(val_a), 0);
        check("t1_lat",    32'(lat_a), 5);
        tick();
        check("t1_done_pulse", 32'(done_a), 0);

        // T2: sel=0; ready[1]@2 ignored, ready[0]@4 -> done@5, latency 4
        s_a = 1; sel_a = 0; op_a = 5;
        tick(); s_a = 0;                        // cycle 1
        tick(); rdy_a = 2'b10;                  // cycle 2
        tick(); rdy_a = 0;                      // cycle 3
        check("t2_busy3",  32'(busy_a), 1);
        check("t2_valid3", 32'(val_a), 32'h1);
        check("t2_done3",  32'(done_a), 0);
        tick(); rdy_a = 2'b01;                  // cycle 4
        tick(); rdy_a = 0;                      // cycle 5
        check("t2_done5", 32'(done_a), 1);
        check("t2_lat",   32'(lat_a), 4);
        // back-to-back: start in the done cycle -> valid@6
        s_a = 1; sel_a = 0; op_a = 1;
        tick(); s_a = 0;                        // cycle 6 (rel 1)
        check("b2b_valid", 32'(val_a), 32'h1);
        check("b2b_busy",  32'(busy_a), 1);
        check("b2b_op",    32'(uop_a), 1);
        check("b2b_done",  32'(done_a), 0);
        // abort alone at rel cycle 3 -> valid drops at rel 4
        tick();                                 // rel 2
        tick(); ab_a = 1;                       // rel 3
        tick(); ab_a = 0;                       // rel 4
        check("ab_valid", 32'(val_a), 0);
        check("ab_busy",  32'(busy_a), 0);
        check("ab_done",  32'(done_a), 0);
        check("ab_to",    32'(to_a), 0);
        check("ab_lat",   32'(lat_a), 4);

        // ready in IDLE ignored
        rdy_a = 2'b11;
        tick(); rdy_a = 0;
        check("idle_rdy_done", 32'(done_a), 0);
        check("idle_rdy_busy", 32'(busy_a), 0);

        // T3: timeout after 8 WAIT cycles -> timeout_err@9
        s_a = 1; sel_a = 1; op_a = 2;
        tick(); s_a = 0;
        for (int c = 1; c <= 8; c++) begin
            check("to_valid", 32'(val_a), 32'h2);
            check("to_early", 32'(to_a), 0);
            tick();
        end
        check("to_pulse", 32'(to_a), 1);
        check("to_valid9", 32'(val_a), 0);
        check("to_busy9", 32'(busy_a), 0);
        check("to_done9", 32'(done_a), 0);
        check("to_lat",   32'(lat_a), 4);
        tick();
        check("to_pulse_end", 32'(to_a), 0);

        // ready together with abort at cycle 2 -> done, latency 2
        s_a = 1; sel_a = 1;
        tick(); s_a = 0;
        tick(); rdy_a = 2'b10; ab_a = 1;
        tick(); rdy_a = 0; ab_a = 0;
        check("rdyab_done", 32'(done_a), 1);
        check("rdyab_lat",  32'(lat_a), 2);

        // ready in the timeout cycle (8) -> done, no timeout_err
        s_a = 1; sel_a = 0;
        tick(); s_a = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) rdy_a = 2'b01;
            tick();
        end
        rdy_a = 0;
        check("rdyto_done", 32'(done_a), 1);
        check("rdyto_to",   32'(to_a), 0);
        check("rdyto_lat",  32'(lat_a), 8);

        // minimum latency: start@T, ready@T+1 -> done@T+2, latency 1
        s_a = 1; sel_a = 1;
        tick(); s_a = 0; rdy_a = 2'b10;
        tick(); rdy_a = 0;
        check("min_done", 32'(done_a), 1);
        check("min_lat",  32'(lat_a), 1);

        // reset mid-WAIT -> all outputs 0, later ready gives no done
        s_a = 1; sel_a = 1; op_a = 6;
        tick(); s_a = 0;                        // cycle 1
        tick(); reset = 1;                      // cycle 2
        tick(); reset = 0;                      // cycle 3
        check("mrst_valid", 32'(val_a), 0);
        check("mrst_op",    32'(uop_a), 0);
        check("mrst_busy",  32'(busy_a), 0);
        check("mrst_lat",   32'(lat_a), 0);
        rdy_a = 2'b10;
        tick(); rdy_a = 0;
        check("mrst_done", 32'(done_a), 0);
        check("mrst_busy2", 32'(busy_a), 0);

        // instance b: illegal select 3 with NUM_UNITS=3
        s_b = 1; sel_b = 3; op_b = 4;
        tick(); s_b = 0;
        check("ill_pulse", 32'(ill_b), 1);
        check("ill_valid", 32'(val_b), 0);
        check("ill_busy",  32'(busy_b), 0);
        tick();
        check("ill_end",   32'(ill_b), 0);
        check("ill_busy2", 32'(busy_b), 0);
        s_b = 1; sel_b = 2;
        tick(); s_b = 0;
        check("b_valid", 32'(val_b), 32'h4);
        check("b_ill",   32'(ill_b), 0);
        rdy_b = 3'b100;
        tick(); rdy_b = 0;
        check("b_done", 32'(done_b), 1);
        check("b_lat",  32'(lat_b), 1);

        // instance c: no timeout, counter saturates at 7
        s_c = 1; sel_c = 0; op_c = 7;
        tick(); s_c = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) begin
                check("sat_valid10", 32'(val_c), 32'h1);
                check("sat_no_to",   32'(to_c), 0);
                rdy_c = 2'b01;
            end
            tick();
        end
        rdy_c = 0;
        check("sat_done", 32'(done_c), 1);
        check("sat_lat",  32'(lat_c), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_unit_sequencer.md
Name: exec_unit_sequencer

Overview:
- Parametrised issue/completion sequencer for N multi-cycle execution units: mul, div, and future units such as FPU or crypto.
- Replaces fixed per-unit valid/ready wiring between the main FSM and the units.
- Adds per-operation timeout, abort, illegal-select detection and last-operation latency measurement.
- Sits between main_fsm and the unit instances; exactly one unit in flight at a time.

Parameters:
- NUM_UNITS, 2, number of attached execution units (1..16).
- SEL_WIDTH, 1, width of unit select; must satisfy 2**SEL_WIDTH >= NUM_UNITS.
- OP_WIDTH, 3, width of the operation code forwarded to the units.
- TIMEOUT_CYCLES, 64, WAIT cycles before abandoning an operation; 0 disables timeout.
- CNT_WIDTH, 8, width of the latency counter; saturating.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; sampled on rising clk.
- start  in  1  single-cycle issue request from main FSM.
- unit_sel  in  SEL_WIDTH  target unit index, sampled with start.
- op  in  OP_WIDTH  operation code, sampled with start.
- abort  in  1  cancel in-flight operation (exception/flush).
- unit_ready  in  NUM_UNITS  per-unit completion strobe.
- unit_valid  out  NUM_UNITS  one-hot request, held until ready/abort/timeout.
- unit_op  out  OP_WIDTH  latched op, stable while busy.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- timeout_err  out  1  one-cycle pulse, operation abandoned.
- illegal_sel  out  1  one-cycle pulse, start with unit_sel >= NUM_UNITS.
- last_latency  out  CNT_WIDTH  WAIT cycles of last completed op.

Behaviour:
- Reset (any state, including mid-operation):
  - state=IDLE.
  - unit_valid=0, unit_op=0, busy=0, done=0, timeout_err=0, illegal_sel=0, last_latency=0, internal counter=0.
  - Any pending unit_ready is ignored.
- All outputs are registered.
- done, timeout_err and illegal_sel are high for exactly one cycle.
- States: IDLE, WAIT.
- IDLE:
  - start & unit_sel<NUM_UNITS: latch unit_sel/op, clear counter, go to WAIT.
  - Next cycle: unit_valid[sel]=1, busy=1.
  - start & unit_sel>=NUM_UNITS: illegal_sel=1 next cycle; stay IDLE; no valid asserted.
  - unit_ready in IDLE: ignored.
- WAIT:
  - unit_valid one-hot at the latched index; unit_op constant.
  - Counter increments each WAIT cycle, starting at 1 in the first WAIT cycle; saturates at 2**CNT_WIDTH-1.
  - unit_ready[sel]=1: next cycle unit_valid=0, busy=0, done=1, last_latency=counter, go to IDLE.
  - unit_ready on a non-selected unit: ignored.
  - abort=1 (and no ready): next cycle unit_valid=0, busy=0; no done; last_latency unchanged; go to IDLE.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES with no ready: next cycle unit_valid=0, busy=0, timeout_err=1; go to IDLE.
- Priority in the same cycle: reset > ready > abort > timeout.
  - A ready arriving together with abort or timeout commits (done=1).
- start while in WAIT is ignored; no queueing.
- Back-to-back:
  - start is accepted in the cycle done is high, since the state is already IDLE.
  - Its unit_valid rises the following cycle.
- Minimum latency:
  - start@T, unit_valid@T+1.
  - ready@T+1 gives done@T+2, last_latency=1.
- Width: the latency counter never wraps.

Test Plan:
- Reset; start unit_sel=1 op=3 at cycle 0; unit_ready[1] at cycle 5 -> unit_valid=2'b10 and unit_op=3 over cycles 1..5; done@6; busy low@6; last_latency=5.
- start unit_sel=0; unit_ready[1] pulsed at cycle 2, unit_ready[0] at cycle 4 -> cycle-2 ready ignored; done@5; last_latency=4.
- TIMEOUT_CYCLES=8; start with no ready -> unit_valid high for 8 cycles; timeout_err pulse@9; done never; last_latency unchanged.
- WAIT, abort and unit_ready[sel] in the same cycle -> done=1, no abort effect. Separate run: abort alone at cycle 3 -> valid drops@4; done=0; timeout_err=0.
- NUM_UNITS=3, SEL_WIDTH=2; start unit_sel=3 -> illegal_sel pulse@1; unit_valid stays 0; busy stays 0.
- ready@4 then start in the done cycle (5) with unit_sel=0 -> unit_valid=01@6. Separately, reset asserted mid-WAIT -> all outputs 0 next cycle; a later ready produces no done.
